// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480 raster timing generator.
// Produces the DrawX/DrawY counters, active-low hs/vs, the active-video flag and
// line/frame strobes. Every output is registered from the next-state counter
// values, so all outputs line up with the DrawX/DrawY shown in the same cycle.
// Optional build macro VGA_ANIM_TICK_EN adds the anim_tick / anim_frame outputs.
module vga_timing_gen #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ANIM_DIV = 8
) (
    input  logic       pixel_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       sync,
    output logic       line_end,
    output logic       frame_start,
    output logic       anim_tick,
    output logic [1:0] anim_frame
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    // Counters are 10 bits wide, so totals above 1024 cannot be represented.
    generate
        if (H_TOT > 1024 || V_TOT > 1024) begin : g_tot_chk
            $error("vga_timing_gen: H_TOT and V_TOT must not exceed 1024");
        end
        if (ANIM_DIV < 1) begin : g_div_chk
            $error("vga_timing_gen: ANIM_DIV must be at least 1");
        end
    endgenerate

    localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_L = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L = 10'(V_VIS);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [9:0] r_hc, r_vc;
    logic       r_hs, r_vs, r_blank, r_line_end, r_frame_start;

    logic [9:0] w_hc_nxt, w_vc_nxt;
    logic       w_h_wrap, w_frame_wrap;

    // Next counter position; the vertical count only moves on a line wrap.
    always_comb begin
        w_h_wrap     = (r_hc == H_LAST);
        w_frame_wrap = w_h_wrap && (r_vc == V_LAST);
        w_hc_nxt     = w_h_wrap ? 10'd0 : r_hc + 10'd1;
        w_vc_nxt     = r_vc;
        if (w_h_wrap) begin
            w_vc_nxt = (r_vc == V_LAST) ? 10'd0 : r_vc + 10'd1;
        end
    end

    // Counters and decoded outputs; decoding the next position keeps zero skew.
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            r_hc          <= 10'd0;
            r_vc          <= 10'd0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank       <= 1'b1;
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hc          <= w_hc_nxt;
            r_vc          <= w_vc_nxt;
            r_hs          <= !((w_hc_nxt >= HS_BEG) && (w_hc_nxt <= HS_END));
            r_vs          <= !((w_vc_nxt >= VS_BEG) && (w_vc_nxt <= VS_END));
            r_blank       <= (w_hc_nxt < H_VIS_L) && (w_vc_nxt < V_VIS_L);
            r_line_end    <= (w_hc_nxt == H_LAST);
            r_frame_start <= w_frame_wrap;
        end
    end

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign blank       = r_blank;
    assign sync        = 1'b0;
    assign line_end    = r_line_end;
    assign frame_start = r_frame_start;

`ifdef VGA_ANIM_TICK_EN
    localparam int FW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(ANIM_DIV - 1);

    logic [FW-1:0] r_fcnt;
    logic          r_anim_tick;
    logic [1:0]    r_anim_frame;

    // Frame counter; its wrap fires anim_tick alongside frame_start and steps the walk frame.
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            r_fcnt       <= '0;
            r_anim_tick  <= 1'b0;
            r_anim_frame <= 2'd0;
        end else begin
            r_anim_tick <= 1'b0;
            if (w_frame_wrap) begin
                if (r_fcnt == F_LAST) begin
                    r_fcnt       <= '0;
                    r_anim_tick  <= 1'b1;
                    r_anim_frame <= (r_anim_frame == 2'd2) ? 2'd0 : r_anim_frame + 2'd1;
                end else begin
                    r_fcnt <= r_fcnt + FW'(1);
                end
            end
        end
    end

    assign anim_tick  = r_anim_tick;
    assign anim_frame = r_anim_frame;
`else
    assign anim_tick  = 1'b0;
    assign anim_frame = 2'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Instance A uses the 640x480 timing for line-level
// checks; instance B uses a tiny raster so whole frames, mid-frame reset and the
// animation tick can be exercised in few cycles. A reference model derives every
// output from the cycle count since reset with plain arithmetic.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       sync;
        logic       line_end;
        logic       frame_start;
        logic       anim_tick;
        logic [1:0] anim_frame;
    } obs_t;

    typedef struct {
        longint t;
        obs_t   exp;
    } vec_t;

    // Small raster for instance B: 16 x 12, frame = 192 cycles.
    localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 3;
    localparam int SVV = 6, SVF = 2, SVS = 2, SVB = 2;
    localparam int SDIV = 2;
    localparam int SFRAME = (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB);

    logic       pixel_clk = 1'b0;
    logic       rst_a_n, rst_b_n;
    logic [9:0] a_x, a_y, b_x, b_y;
    logic       a_hs, a_vs, a_blank, a_sync, a_le, a_fs, a_at;
    logic       b_hs, b_vs, b_blank, b_sync, b_le, b_fs, b_at;
    logic [1:0] a_af, b_af;
    obs_t       a_obs, b_obs;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_a   = 1'b0;
    bit  chk_b   = 1'b0;
    longint t_a = 0, t_b = 0;

    always #20 pixel_clk = ~pixel_clk;

    vga_timing_gen u_a (
        .pixel_clk(pixel_clk), .reset_n(rst_a_n), .DrawX(a_x), .DrawY(a_y),
        .hs(a_hs), .vs(a_vs), .blank(a_blank), .sync(a_sync), .line_end(a_le),
        .frame_start(a_fs), .anim_tick(a_at), .anim_frame(a_af)
    );

    vga_timing_gen #(
        .H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .ANIM_DIV(SDIV)
    ) u_b (
        .pixel_clk(pixel_clk), .reset_n(rst_b_n), .DrawX(b_x), .DrawY(b_y),
        .hs(b_hs), .vs(b_vs), .blank(b_blank), .sync(b_sync), .line_end(b_le),
        .frame_start(b_fs), .anim_tick(b_at), .anim_frame(b_af)
    );

    assign a_obs = {a_x, a_y, a_hs, a_vs, a_blank, a_sync, a_le, a_fs, a_at, a_af};
    assign b_obs = {b_x, b_y, b_hs, b_vs, b_blank, b_sync, b_le, b_fs, b_at, b_af};

    // Reference: t = cycles since the last reset edge.
    function automatic obs_t model(input longint t, input int hv, hf, hsw, hb,
                                   input int vv, vf, vsw, vb, div);
        obs_t   o;
        longint htot, vtot, frame, x, y, nf;
        bit     fs;
        htot  = hv + hf + hsw + hb;
        vtot  = vv + vf + vsw + vb;
        frame = htot * vtot;
        x     = t % htot;
        y     = (t / htot) % vtot;
        nf    = t / frame;
        fs    = (t > 0) && (t % frame == 0);
        o     = '0;
        o.x   = 10'(x);
        o.y   = 10'(y);
        o.hs  = !((x >= hv + hf) && (x < hv + hf + hsw));
        o.vs  = !((y >= vv + vf) && (y < vv + vf + vsw));
        o.blank       = (x < hv) && (y < vv);
        o.sync        = 1'b0;
        o.line_end    = (x == htot - 1);
        o.frame_start = fs;
`ifdef VGA_ANIM_TICK_EN
        o.anim_tick  = fs && (nf % div == 0);
        o.anim_frame = 2'((nf / div) % 3);
`else
        o.anim_tick  = 1'b0;
        o.anim_frame = (div < 0) ? 2'd1 : 2'd0;
`endif
        return o;
    endfunction

    function automatic obs_t mk(input int x, y, input bit h, v, bl, le);
        obs_t o;
        o = '0;
        o.x = 10'(x); o.y = 10'(y);
        o.hs = h; o.vs = v; o.blank = bl; o.line_end = le;
        return o;
    endfunction

    task automatic check_obs(input string name, input longint t, input obs_t act, input obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model cycle counters follow each instance's reset.
    always @(posedge pixel_clk) begin
        t_a <= (!rst_a_n) ? 0 : t_a + 1;
        t_b <= (!rst_b_n) ? 0 : t_b + 1;
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge pixel_clk) begin
        if (chk_a) check_obs("cycle A", t_a, a_obs, model(t_a, 640, 16, 96, 48, 480, 10, 2, 33, 8));
        if (chk_b) check_obs("cycle B", t_b, b_obs, model(t_b, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, SDIV));
    end

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[12];
        obs_t rst_obs;
        int   guard, cnt_hs, cnt_le, cnt_vs, cnt_tick, first_fs, bad_af, n_rst;
        int   tick_af[$];

        rst_obs = mk(0, 0, 1, 1, 1, 0);
        vt[0]  = '{0,    mk(0,   0, 1, 1, 1, 0)};
        vt[1]  = '{1,    mk(1,   0, 1, 1, 1, 0)};
        vt[2]  = '{639,  mk(639, 0, 1, 1, 1, 0)};
        vt[3]  = '{640,  mk(640, 0, 1, 1, 0, 0)};
        vt[4]  = '{655,  mk(655, 0, 1, 1, 0, 0)};
        vt[5]  = '{656,  mk(656, 0, 0, 1, 0, 0)};
        vt[6]  = '{751,  mk(751, 0, 0, 1, 0, 0)};
        vt[7]  = '{752,  mk(752, 0, 1, 1, 0, 0)};
        vt[8]  = '{799,  mk(799, 0, 1, 1, 0, 1)};
        vt[9]  = '{800,  mk(0,   1, 1, 1, 1, 0)};
        vt[10] = '{1439, mk(639, 1, 1, 1, 1, 0)};
        vt[11] = '{1600, mk(0,   2, 1, 1, 1, 0)};

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (2) @(posedge pixel_clk);
        @(negedge pixel_clk);
        check_obs("reset A", 0, a_obs, rst_obs);
        check_obs("reset B", 0, b_obs, rst_obs);
        chk_a = 1'b1;
        chk_b = 1'b1;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        // Table of 640x480 landmarks on instance A.
        for (int i = 0; i < 12; i++) begin
            guard = 0;
            while (t_a < vt[i].t && guard < 5000) begin
                @(negedge pixel_clk);
                guard++;
            end
            check_obs("table A", t_a, a_obs, vt[i].exp);
        end

        // One full line (line 2): hs low exactly 96 cycles, line_end exactly once.
        cnt_hs = 0; cnt_le = 0;
        for (int k = 0; k < 800; k++) begin
            if (!a_hs) begin
                cnt_hs++;
                if (a_x < 656 || a_x > 751) check_int("hs position", int'(a_x), 656);
            end
            if (a_le) cnt_le++;
            @(negedge pixel_clk);
        end
        check_int("hs low cycles", cnt_hs, 96);
        check_int("line_end count", cnt_le, 1);

        // Mid-frame reset on B inside both sync pulses (x=11, y=9).
        guard = 0;
        while (!(b_x == 10'd11 && b_y == 10'd9) && guard < 1000) begin
            @(negedge pixel_clk);
            guard++;
        end
        check_int("reach x11 y9", guard < 1000 ? 1 : 0, 1);
        check_int("in hs+vs pulse", {b_hs, b_vs}, 0);
        rst_b_n = 1'b0;
        @(negedge pixel_clk);
        check_obs("midframe reset B", t_b, b_obs, rst_obs);
        rst_b_n = 1'b1;

        // Seven frames on B from t=0: frame_start timing, vs width, animation.
        cnt_vs = 0; cnt_tick = 0; first_fs = -1; bad_af = 0;
        for (int k = 0; k < 7 * SFRAME + 5; k++) begin
            if (b_fs && first_fs < 0) first_fs = k;
            if (k < SFRAME && !b_vs) cnt_vs++;
            if (b_at) begin
                cnt_tick++;
                tick_af.push_back(int'(b_af));
            end
            if (b_af == 2'd3) bad_af++;
`ifndef VGA_ANIM_TICK_EN
            if (b_af != 2'd0) bad_af++;
`endif
            @(negedge pixel_clk);
        end
        check_int("first frame_start cycle", first_fs, SFRAME);
        check_int("vs low cycles", cnt_vs, 2 * 16);
        check_int("bad anim_frame", bad_af, 0);
`ifdef VGA_ANIM_TICK_EN
        check_int("anim_tick count", cnt_tick, 3);
        if (tick_af.size() == 3) begin
            check_int("anim_frame at tick 1", tick_af[0], 1);
            check_int("anim_frame at tick 2", tick_af[1], 2);
            check_int("anim_frame at tick 3", tick_af[2], 0);
        end
`else
        check_int("anim_tick count", cnt_tick, 0);
`endif

        // Random resets on both instances; the per-cycle model checks everything.
        n_rst = 0;
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(299, 0) == 0) begin
                n_rst++;
                if ($urandom_range(1, 0) == 0) rst_a_n = 1'b0;
                else rst_b_n = 1'b0;
                repeat ($urandom_range(3, 1)) @(negedge pixel_clk);
                rst_a_n = 1'b1;
                rst_b_n = 1'b1;
            end
            @(negedge pixel_clk);
        end

        chk_a = 1'b0;
        chk_b = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
